// File: rtl/logic_pkg.sv
// Shared constants for the logic arbiter: bitwise op codes and FSM state encodings.
package logic_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/logic_unit.sv
// Purely combinational bitwise unit shared by both requesters.
module logic_unit
  import logic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_arbiter.sv
// Two-requester round-robin arbiter in front of a shared bitwise logic unit.
// Handshake: reqN is held high until doneN; gntN pulses one cycle after acceptance, doneN pulses once with result.
module logic_arbiter
  import logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state
);

  logic [1:0]       r_state;
  logic             r_sel;
  logic             r_last;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_result;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic [CNT_W-1:0] r_count;

  logic             w_any;
  logic             w_pick1;
  logic [WIDTH-1:0] w_y;

  // r_last = 1 means requester 1 was served last, so requester 0 wins a tie.
  always_comb begin
    w_any   = req0 | req1;
    w_pick1 = req1 & (~req0 | ~r_last);
  end

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .a  (r_a),
    .b  (r_b),
    .op (r_op),
    .y  (w_y)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= 1'b0;
      r_last   <= 1'b1;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_y      <= '0;
      r_result <= '0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_count  <= '0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_sel   <= w_pick1;
            r_last  <= w_pick1;
            r_op    <= w_pick1 ? op1 : op0;
            r_a     <= w_pick1 ? a1 : a0;
            r_b     <= w_pick1 ? b1 : b0;
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_y     <= w_y;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          // Result is published together with done so it only changes on done cycles.
          r_result <= r_y;
          r_done0  <= ~r_sel;
          r_done1  <= r_sel;
          r_count  <= r_count + CNT_W'(1);
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    gnt0      = r_gnt0;
    gnt1      = r_gnt1;
    done0     = r_done0;
    done1     = r_done1;
    result    = r_result;
    busy      = (r_state != ST_IDLE);
    op_count  = r_count;
    dbg_state = r_state;
  end

endmodule
